// File: rtl/uart_receiver_pkg.sv
// Shared types and constants for the console UART receive path.
package uart_receiver_pkg;

    localparam int unsigned CONSOLE_BAUD = 115200;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_rx_state_e;

endpackage

// File: rtl/uart_receiver_baud_tick_gen.sv
// Free-running oversample tick generator: one-clock tick every CLK_FREQ/(BAUD*OVERSAMPLE) clocks.
module baud_tick_gen #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        tick_d = (cnt_q == CNT_W'(DIV - 1));
        cnt_d  = tick_d ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with byte/strobe output, line-error pulses and busy/debug status.
// Define UART_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = CONSOLE_BAUD,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       dataReady,
    output logic       framingError,
    output logic       parityError,
    output logic       busy,
    output logic [7:0] debug
);

    localparam int unsigned SCNT_W = $clog2(OVERSAMPLE);
    localparam logic [SCNT_W-1:0] SCNT_HALF = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);

    logic tick;

    baud_tick_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    logic rx_meta_q, rxs_q;

    uart_rx_state_e    state_q, state_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic [2:0]        bcnt_q, bcnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        data_q, data_d;
    logic              ready_q, ready_d;
    logic              ferr_q, ferr_d;
    logic              perr_q, perr_d;
    logic              busy_q, busy_d;
    logic              par_fault;

`ifdef UART_PARITY_EN
    logic par_fault_q, par_fault_d;
    assign par_fault = par_fault_q;
`else
    assign par_fault = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        ready_d = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
`ifdef UART_PARITY_EN
        par_fault_d = par_fault_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d = START;
                    scnt_d  = '0;
                end
            end
            // Re-check the start bit at its midpoint to reject glitches.
            START: begin
                if (tick) begin
                    if (scnt_q == SCNT_HALF) begin
                        if (rxs_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            scnt_d  = '0;
                            bcnt_d  = '0;
                        end
                    end else begin
                        scnt_d = scnt_q + SCNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (scnt_q == SCNT_LAST) begin
                        shift_d = {rxs_q, shift_q[7:1]};
                        scnt_d  = '0;
                        bcnt_d  = bcnt_q + 3'd1;
                        if (bcnt_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        scnt_d = scnt_q + SCNT_W'(1);
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (scnt_q == SCNT_LAST) begin
                        par_fault_d = rxs_q ^ (^shift_q);
                        scnt_d      = '0;
                        state_d     = STOP;
                    end else begin
                        scnt_d = scnt_q + SCNT_W'(1);
                    end
                end
            end
`endif
            // Leave at mid-stop so an immediately following start edge is caught.
            STOP: begin
                if (tick) begin
                    if (scnt_q == SCNT_LAST) begin
                        scnt_d = '0;
                        if (rxs_q) begin
                            state_d = IDLE;
                            if (par_fault) begin
                                perr_d = 1'b1;
                            end else begin
                                data_d  = shift_q;
                                ready_d = 1'b1;
                            end
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        scnt_d = scnt_q + SCNT_W'(1);
                    end
                end
            end
            BREAK: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= IDLE;
            scnt_q    <= '0;
            bcnt_q    <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            scnt_q    <= scnt_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            busy_q    <= busy_d;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_fault_q <= 1'b0;
        end else begin
            par_fault_q <= par_fault_d;
        end
    end
`endif

    assign data         = data_q;
    assign dataReady    = ready_q;
    assign framingError = ferr_q;
    assign parityError  = perr_q;
    assign busy         = busy_q;
    assign debug        = {5'b0, state_q};

endmodule
